conv_psum_acc: RTL and testbench



---
 rtl/conv_pkg.sv | 17 +
 rtl/conv_psum_acc_sat_add_lane.sv | 33 +++
 rtl/conv_psum_acc.sv | 231 +++++++++++++++++++++++
 tb/tb_conv_psum_acc.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution partial-sum accumulator.
// Holds the controller state encoding and the default geometry constants
// used as parameter defaults by conv_psum_acc.
package conv_pkg;

    localparam int AW_DEF = 8;   // bias / partial-sum RAM address width
    localparam int DW_DEF = 22;  // signed lane width
    localparam int DN_DEF = 4;   // lanes per beat
    localparam int CW_DEF = 11;  // job size field width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/conv_psum_acc_sat_add_lane.sv
// sat_add_lane: one lane of the accumulator datapath.
// Adds two signed DW-bit operands at DW+1 bits, saturates the result back to
// the signed DW-bit range, then optionally clamps negative results to zero.
// Ports:
//   i_a, i_b  DW-bit two's-complement operands
//   i_relu    force negative results to zero
//   o_y       saturated (and optionally rectified) sum
module sat_add_lane #(
    parameter int DW = 22
) (
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic          i_relu,
    output logic [DW-1:0] o_y
);

    logic [DW:0]   w_sum;
    logic [DW-1:0] w_sat;

    // Sign-extend both operands by one bit so the carry into the extra bit
    // reveals overflow.
    assign w_sum = {i_a[DW-1], i_a} + {i_b[DW-1], i_b};

    always_comb begin
        w_sat = w_sum[DW-1:0];
        // Top two bits disagree only when the true sum left the DW-bit range.
        if (w_sum[DW] != w_sum[DW-1]) begin
            w_sat = w_sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
        o_y = (i_relu && w_sat[DW-1]) ? '0 : w_sat;
    end

endmodule

// File: rtl/conv_psum_acc.sv
// conv_psum_acc: accumulates convolution partial sums over a job of `size`
// beats. Each accepted input beat is added lane-wise to either a bias vector
// (first kernel pass) or the previously stored partial sum, both fetched from
// synchronous-read RAMs. Intermediate passes write the result back to the
// partial-sum RAM; the last pass streams it out (optionally rectified).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start/size/first_k/last_k/relu_en/base_bias/base_psum   job request
//   in_data/in_valid/in_ready                                input stream
//   bias_addr/bias_data, psum_raddr/psum_rdata               RAM reads
//   psum_waddr/psum_wdata/psum_wen                           RAM write
//   out_data/out_valid/out_ready                             result stream
//   busy, done                                               job status
module conv_psum_acc
    import conv_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int DN = DN_DEF,
    parameter int CW = CW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CW-1:0]    size,
    input  logic             first_k,
    input  logic             last_k,
    input  logic             relu_en,
    input  logic [AW-1:0]    base_bias,
    input  logic [AW-1:0]    base_psum,
    input  logic [DW*DN-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [AW-1:0]    bias_addr,
    output logic [AW-1:0]    psum_raddr,
    input  logic [DW*DN-1:0] bias_data,
    input  logic [DW*DN-1:0] psum_rdata,
    output logic [AW-1:0]    psum_waddr,
    output logic [DW*DN-1:0] psum_wdata,
    output logic             psum_wen,
    output logic [DW*DN-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    localparam int BW = DW * DN;

    state_t          r_state, w_state_next;
    logic            r_done, w_done_next;

    // Job fields captured at start
    logic [CW-1:0]   r_size;
    logic            r_first_k, r_last_k, r_relu;
    logic [AW-1:0]   r_base_bias, r_base_psum;
    logic [CW-1:0]   r_idx;

    // Stage 1: accepted beat waiting for its RAM read data
    logic            r_s1_valid;
    logic [BW-1:0]   r_s1_data;
    logic [AW-1:0]   r_s1_addr;
    logic            r_s1_hold;
    logic [BW-1:0]   r_s1_op;

    // Stage 2: partial-sum write-back register
    logic            r_wr_valid;
    logic [AW-1:0]   r_wr_addr;
    logic [BW-1:0]   r_wr_data;

    // Output register for the final pass
    logic            r_out_valid;
    logic [BW-1:0]   r_out_data;

    logic            w_in_ready, w_busy;
    logic            w_acc, w_stall, w_s1_adv, w_last_beat, w_run;
    logic [AW-1:0]   w_idx_a, w_bias_addr, w_psum_addr;
    logic [BW-1:0]   w_op, w_sum;

    assign w_run       = (r_state == RUN);
    assign w_idx_a     = AW'(r_idx);
    assign w_bias_addr = r_base_bias + w_idx_a;
    assign w_psum_addr = r_base_psum + w_idx_a;

    assign w_stall     = r_out_valid & ~out_ready & r_s1_valid;
    assign w_acc       = in_valid & w_in_ready;
    assign w_s1_adv    = r_s1_valid & ~w_stall;
    assign w_last_beat = (r_idx == (r_size - CW'(1)));

    // The RAM only presents read data for the cycle after the address. If
    // stage 1 stalls, that data would be replaced by the next beat's read, so
    // the operand is captured on the first stall cycle and reused afterwards.
    assign w_op = r_s1_hold ? r_s1_op : (r_first_k ? bias_data : psum_rdata);

    genvar gi;
    generate
        for (gi = 0; gi < DN; gi++) begin : g_lane
            sat_add_lane #(.DW(DW)) u_lane (
                .i_a    (r_s1_data[DW*gi +: DW]),
                .i_b    (w_op[DW*gi +: DW]),
                .i_relu (r_relu & r_last_k),
                .o_y    (w_sum[DW*gi +: DW])
            );
        end
    endgenerate

    // ---------------- controller ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        w_in_ready   = (r_state == RUN) & ~(r_last_k & w_stall);
        w_busy       = (r_state == RUN) | (r_state == DRAIN);
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (size != '0) w_state_next = RUN;
                    else            w_done_next  = 1'b1;
                end
            end
            RUN: begin
                if (w_acc && w_last_beat) w_state_next = DRAIN;
            end
            DRAIN: begin
                if (!r_s1_valid && !r_wr_valid && !r_out_valid) begin
                    w_state_next = IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ---------------- job fields and beat counter ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_size      <= '0;
            r_first_k   <= 1'b0;
            r_last_k    <= 1'b0;
            r_relu      <= 1'b0;
            r_base_bias <= '0;
            r_base_psum <= '0;
            r_idx       <= '0;
        end else if (r_state == IDLE) begin
            if (start && size != '0) begin
                r_size      <= size;
                r_first_k   <= first_k;
                r_last_k    <= last_k;
                r_relu      <= relu_en;
                r_base_bias <= base_bias;
                r_base_psum <= base_psum;
                r_idx       <= '0;
            end
        end else if (w_acc) begin
            r_idx <= r_idx + CW'(1);
        end
    end

    // ---------------- stage 1 ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_addr  <= '0;
            r_s1_hold  <= 1'b0;
            r_s1_op    <= '0;
        end else if (w_acc) begin
            r_s1_valid <= 1'b1;
            r_s1_data  <= in_data;
            r_s1_addr  <= w_psum_addr;
            r_s1_hold  <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
            r_s1_hold  <= 1'b0;
        end else if (w_stall) begin
            r_s1_hold  <= 1'b1;
            r_s1_op    <= w_op;
        end
    end

    // ---------------- stage 2: partial-sum write-back ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_valid <= w_s1_adv & ~r_last_k;
            if (w_s1_adv && !r_last_k) begin
                r_wr_addr <= r_s1_addr;
                r_wr_data <= w_sum;
            end
        end
    end

    // ---------------- output register ----------------
    // A new result may load in the same cycle the old one is taken, so a
    // continuously ready consumer sees one result per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_s1_adv && r_last_k) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sum;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready   = w_in_ready;
    assign busy       = w_busy;
    assign done       = r_done;
    assign bias_addr  = w_run ? w_bias_addr : '0;
    assign psum_raddr = w_run ? w_psum_addr : '0;
    assign psum_waddr = r_wr_addr;
    assign psum_wdata = r_wr_data;
    assign psum_wen   = r_wr_valid;
    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;

endmodule

// File: tb/tb_conv_psum_acc.sv
module tb_conv_psum_acc;

    localparam int AW = 8;
    localparam int DW = 22;
    localparam int DN = 4;
    localparam int CW = 11;
    localparam int BW = DW * DN;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] size;
    logic          first_k, last_k, relu_en;
    logic [AW-1:0] base_bias, base_psum;
    logic [BW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] bias_addr, psum_raddr, psum_waddr;
    logic [BW-1:0] bias_data, psum_rdata, psum_wdata, out_data;
    logic          psum_wen, out_valid, out_ready, busy, done;

    logic [BW-1:0] bias_mem [0:255];
    logic [BW-1:0] psum_mem [0:255];

    logic [AW-1:0] wr_addr_q [$];
    logic [BW-1:0] wr_data_q [$];
    logic [BW-1:0] out_q [$];
    int            ov_cnt   = 0;
    int            done_cnt = 0;

    int n_cmp = 0;
    int n_err = 0;

    conv_psum_acc #(.AW(AW), .DW(DW), .DN(DN), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .size(size),
        .first_k(first_k), .last_k(last_k), .relu_en(relu_en),
        .base_bias(base_bias), .base_psum(base_psum),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .bias_addr(bias_addr), .psum_raddr(psum_raddr),
        .bias_data(bias_data), .psum_rdata(psum_rdata),
        .psum_waddr(psum_waddr), .psum_wdata(psum_wdata), .psum_wen(psum_wen),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM models
    always @(posedge clk) begin
        bias_data  <= bias_mem[bias_addr];
        psum_rdata <= psum_mem[psum_raddr];
    end

    // Transaction monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (psum_wen) begin
            wr_addr_q.push_back(psum_waddr);
            wr_data_q.push_back(psum_wdata);
            $display("[%0t] psum write addr=%0d lane0=%0d", $time, psum_waddr, lane(psum_wdata, 0));
        end
        if (out_valid) ov_cnt++;
        if (out_valid && out_ready) begin
            out_q.push_back(out_data);
            $display("[%0t] output lane0=%0d lane1=%0d", $time, lane(out_data, 0), lane(out_data, 1));
        end
        if (done) done_cnt++;
    end

    function automatic logic [BW-1:0] pack4(input int a, input int b, input int c, input int d);
        return {d[DW-1:0], c[DW-1:0], b[DW-1:0], a[DW-1:0]};
    endfunction

    function automatic int lane(input logic [BW-1:0] v, input int i);
        logic signed [DW-1:0] t;
        t = v[DW*i +: DW];
        return int'(t);
    endfunction

    task automatic start_job(input int sz, input logic fk, input logic lk, input logic re,
                             input int bb, input int bp);
        size      = CW'(sz);
        first_k   = fk;
        last_k    = lk;
        relu_en   = re;
        base_bias = AW'(bb);
        base_psum = AW'(bp);
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic send_beat(input logic [BW-1:0] d, output bit ok);
        ok       = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (seen !== 1'b1) begin
            n_err++;
            $display("FAIL %s_done_timeout got=%0d want=1", name, seen);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({in_ready, psum_wen, out_valid, busy, done} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_ctrl got=%b want=00000", {in_ready, psum_wen, out_valid, busy, done});
        end
        n_cmp++;
        if ({bias_addr, psum_raddr, psum_waddr} !== '0) begin
            n_err++;
            $display("FAIL reset_addr got=%0d/%0d/%0d want=0/0/0", bias_addr, psum_raddr, psum_waddr);
        end
        n_cmp++;
        if ({psum_wdata, out_data} !== '0) begin
            n_err++;
            $display("FAIL reset_data got=%h/%h want=0", psum_wdata, out_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_size_zero;
        int bd = done_cnt;
        start_job(0, 1'b1, 1'b0, 1'b0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL size0_pulse got done=%b busy=%b want done=1 busy=0", done, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || done_cnt - bd !== 1) begin
            n_err++;
            $display("FAIL size0_once got done=%b count=%0d want done=0 count=1", done, done_cnt - bd);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_psum_write;
        int bw = wr_addr_q.size();
        int bo = ov_cnt;
        bit ok;
        int ins [3] = '{15, 20, -30};
        int bis [3] = '{8, 11, -9};
        int exp [3] = '{23, 31, -39};
        for (int i = 0; i < 8; i++) bias_mem[10+i] = (i < 3) ? pack4(bis[i], 0, 0, 0) : '0;
        start_job(8, 1'b1, 1'b0, 1'b0, 10, 0);
        for (int i = 0; i < 8; i++) begin
            send_beat((i < 3) ? pack4(ins[i], 0, 0, 0) : '0, ok);
            n_cmp++;
            if (!ok) begin n_err++; $display("FAIL psum_accept beat=%0d got=0 want=1", i); end
        end
        wait_done("psum");
        n_cmp++;
        if (wr_addr_q.size() - bw !== 8) begin
            n_err++;
            $display("FAIL psum_count got=%0d want=8", wr_addr_q.size() - bw);
        end
        for (int i = 0; i < 3; i++) begin
            if (bw + i < wr_addr_q.size()) begin
                n_cmp++;
                if (wr_addr_q[bw+i] !== AW'(i) || lane(wr_data_q[bw+i], 0) !== exp[i]) begin
                    n_err++;
                    $display("FAIL psum_write%0d got addr=%0d data=%0d want addr=%0d data=%0d",
                             i, wr_addr_q[bw+i], lane(wr_data_q[bw+i], 0), i, exp[i]);
                end
            end
        end
        n_cmp++;
        if (ov_cnt - bo !== 0) begin
            n_err++;
            $display("FAIL psum_no_out got=%0d want=0", ov_cnt - bo);
        end
    endtask

    task automatic test_relu_out;
        int bo = out_q.size();
        int bw = wr_addr_q.size();
        bit ok;
        int ps  [4] = '{5, -50, 0, 7};
        int exp [4] = '{25, 0, 22, 30};
        for (int i = 0; i < 4; i++) psum_mem[i] = pack4(ps[i], 10, 0, 0);
        out_ready = 1'b1;
        start_job(4, 1'b0, 1'b1, 1'b1, 0, 0);
        for (int i = 0; i < 4; i++) send_beat(pack4(20 + i, 1, 0, 0), ok);
        wait_done("relu");
        n_cmp++;
        if (out_q.size() - bo !== 4) begin
            n_err++;
            $display("FAIL relu_count got=%0d want=4", out_q.size() - bo);
        end
        for (int i = 0; i < 4; i++) begin
            if (bo + i < out_q.size()) begin
                n_cmp++;
                if (lane(out_q[bo+i], 0) !== exp[i]) begin
                    n_err++;
                    $display("FAIL relu_out%0d got=%0d want=%0d", i, lane(out_q[bo+i], 0), exp[i]);
                end
            end
        end
        if (bo + 1 < out_q.size()) begin
            n_cmp++;
            if (lane(out_q[bo+1], 1) !== 11) begin
                n_err++;
                $display("FAIL relu_lane_indep got=%0d want=11", lane(out_q[bo+1], 1));
            end
        end
        n_cmp++;
        if (wr_addr_q.size() - bw !== 0) begin
            n_err++;
            $display("FAIL relu_no_write got=%0d want=0", wr_addr_q.size() - bw);
        end
    endtask

    task automatic test_saturation;
        int bo = out_q.size();
        bit ok;
        int exp [4] = '{2097151, -2097152, 105, -13};
        bias_mem[20] = pack4(1000, -1000, 5, -3);
        out_ready = 1'b1;
        start_job(1, 1'b1, 1'b1, 1'b0, 20, 0);
        send_beat(pack4(2097000, -2097000, 100, -10), ok);
        wait_done("sat");
        n_cmp++;
        if (out_q.size() - bo !== 1) begin
            n_err++;
            $display("FAIL sat_count got=%0d want=1", out_q.size() - bo);
        end else begin
            for (int l = 0; l < 4; l++) begin
                n_cmp++;
                if (lane(out_q[bo], l) !== exp[l]) begin
                    n_err++;
                    $display("FAIL sat_lane%0d got=%0d want=%0d", l, lane(out_q[bo], l), exp[l]);
                end
            end
        end
    endtask

    task automatic test_stall;
        int bo = out_q.size();
        int bd = done_cnt;
        logic [BW-1:0] held;
        bit saw_low = 1'b0;
        bit hold_ok = 1'b1;
        for (int i = 0; i < 6; i++) bias_mem[30+i] = pack4(10 * (i + 1), 0, 0, 0);
        out_ready = 1'b1;
        start_job(6, 1'b1, 1'b1, 1'b0, 30, 0);
        fork
            begin
                bit ok;
                for (int i = 0; i < 6; i++) begin
                    send_beat(pack4(i + 1, 1, 2, 3), ok);
                    n_cmp++;
                    if (!ok) begin n_err++; $display("FAIL stall_accept beat=%0d got=0 want=1", i); end
                end
            end
            begin
                for (int c = 0; c < 50 && !out_valid; c++) @(negedge clk);
                @(posedge clk); #1;
                out_ready = 1'b0;
                @(negedge clk);
                held = out_data;
                for (int c = 0; c < 5; c++) begin
                    if (c > 0) @(negedge clk);
                    if (out_valid !== 1'b1 || out_data !== held) hold_ok = 1'b0;
                    if (in_ready === 1'b0) saw_low = 1'b1;
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        wait_done("stall");
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (hold_ok !== 1'b1) begin n_err++; $display("FAIL stall_hold got=%0d want=1", hold_ok); end
        n_cmp++;
        if (saw_low !== 1'b1) begin n_err++; $display("FAIL stall_in_ready_low got=%0d want=1", saw_low); end
        n_cmp++;
        if (out_q.size() - bo !== 6) begin
            n_err++;
            $display("FAIL stall_count got=%0d want=6", out_q.size() - bo);
        end
        for (int i = 0; i < 6; i++) begin
            if (bo + i < out_q.size()) begin
                n_cmp++;
                if (lane(out_q[bo+i], 0) !== 11 * (i + 1)) begin
                    n_err++;
                    $display("FAIL stall_out%0d got=%0d want=%0d", i, lane(out_q[bo+i], 0), 11 * (i + 1));
                end
            end
        end
        n_cmp++;
        if (done_cnt - bd !== 1) begin
            n_err++;
            $display("FAIL stall_done_once got=%0d want=1", done_cnt - bd);
        end
    endtask

    task automatic test_wrap;
        int bw = wr_addr_q.size();
        bit ok;
        int exp [4] = '{254, 255, 0, 1};
        start_job(4, 1'b1, 1'b0, 1'b0, 0, 254);
        // A start while running must not disturb the latched job fields.
        start     = 1'b1;
        size      = CW'(1);
        base_psum = AW'(100);
        for (int i = 0; i < 4; i++) send_beat(pack4(i, 0, 0, 0), ok);
        start = 1'b0;
        wait_done("wrap");
        n_cmp++;
        if (wr_addr_q.size() - bw !== 4) begin
            n_err++;
            $display("FAIL wrap_count got=%0d want=4", wr_addr_q.size() - bw);
        end
        for (int i = 0; i < 4; i++) begin
            if (bw + i < wr_addr_q.size()) begin
                n_cmp++;
                if (wr_addr_q[bw+i] !== AW'(exp[i])) begin
                    n_err++;
                    $display("FAIL wrap_addr%0d got=%0d want=%0d", i, wr_addr_q[bw+i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_rst_midjob;
        int bw, bo, bd;
        bit ok;
        start_job(8, 1'b1, 1'b0, 1'b0, 0, 0);
        send_beat(pack4(1, 0, 0, 0), ok);
        send_beat(pack4(2, 0, 0, 0), ok);
        in_data  = pack4(3, 0, 0, 0);
        in_valid = 1'b1;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        bw = wr_addr_q.size();
        bo = ov_cnt;
        bd = done_cnt;
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b want=0", busy); end
        start_job(2, 1'b1, 1'b0, 1'b0, 0, 50);
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL rst_restart got=%b want=1", busy); end
        send_beat(pack4(4, 0, 0, 0), ok);
        send_beat(pack4(5, 0, 0, 0), ok);
        wait_done("rst");
        n_cmp++;
        if (wr_addr_q.size() - bw !== 2 || ov_cnt - bo !== 0 || done_cnt - bd !== 1) begin
            n_err++;
            $display("FAIL rst_after got writes=%0d outs=%0d done=%0d want writes=2 outs=0 done=1",
                     wr_addr_q.size() - bw, ov_cnt - bo, done_cnt - bd);
        end
        if (bw + 1 < wr_addr_q.size()) begin
            n_cmp++;
            if (wr_addr_q[bw] !== AW'(50) || wr_addr_q[bw+1] !== AW'(51)) begin
                n_err++;
                $display("FAIL rst_new_addr got=%0d,%0d want=50,51", wr_addr_q[bw], wr_addr_q[bw+1]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; size = '0;
        first_k = 1'b0; last_k = 1'b0; relu_en = 1'b0;
        base_bias = '0; base_psum = '0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bias_mem[i] = '0;
            psum_mem[i] = '0;
        end
        test_reset();
        test_size_zero();
        test_psum_write();
        test_relu_out();
        test_saturation();
        test_stall();
        test_wrap();
        test_rst_midjob();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
